// File: rtl/truth_table_sweep_pkg.sv
// Shared constants for the truth-table sweeper: state encodings, vector count
// and a helper that sizes the dwell counter.
package truth_table_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int NUM_VECTORS = 16;
  localparam int IDX_W       = $clog2(NUM_VECTORS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

  // A one-cycle dwell still needs a one-bit counter to exist.
  function automatic int dwell_cnt_w(input int dwell);
    return (dwell > 1) ? $clog2(dwell) : 1;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter: counts 0..DWELL-1 while enabled, flags the last count and
// restarts from zero on the following edge.
module dwell_timer
  import truth_table_sweep_pkg::*;
#(
  parameter int DWELL = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = dwell_cnt_w(DWELL);
  localparam logic [CW-1:0] LAST_CNT = CW'(DWELL - 1);

  logic [CW-1:0] count_q, count_d;

  assign expire = (count_q == LAST_CNT);

  // Restarting on expire keeps the count inside 0..DWELL-1 for any DWELL.
  always_comb begin
    count_d = count_q;
    if (clear || (enable && expire)) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/truth_table_sweep.sv
// Steps a 4-input circuit through all 16 input vectors, holding each for DWELL
// cycles, and captures the response into a 16-bit truth table.
//
//   state | meaning
//   IDLE  | waiting for start; vector 0000 driven, last table held
//   APPLY | vector idx driven; sample dut_out when the dwell expires
//   DONE  | one-cycle completion pulse, then back to IDLE
module truth_table_sweep
  import truth_table_sweep_pkg::*;
#(
  parameter int DWELL = 100
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   dut_out,
  output logic                   a,
  output logic                   b,
  output logic                   c,
  output logic                   d,
  output logic [IDX_W-1:0]       idx,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_VECTORS-1:0] table_out,
  output logic [IDX_W:0]         ones_cnt
);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [NUM_VECTORS-1:0] table_q, table_d;
  logic [IDX_W:0]         ones_q, ones_d;
  logic                   expire;

  dwell_timer #(.DWELL(DWELL)) u_dwell_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q != APPLY),
    .enable (state_q == APPLY),
    .expire (expire)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    table_d = table_q;
    ones_d  = ones_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = APPLY;
          idx_d   = '0;
          table_d = '0;
          ones_d  = '0;
          busy_d  = 1'b1;
        end
      end
      APPLY: begin
        busy_d = 1'b1;
        if (expire) begin
          table_d[idx_q] = dut_out;
          ones_d         = ones_q + {{IDX_W{1'b0}}, dut_out};
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      table_q <= '0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      table_q <= table_d;
      ones_q  <= ones_d;
    end
  end

  assign {a, b, c, d} = idx_q;
  assign idx          = idx_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign table_out    = table_q;
  assign ones_cnt     = ones_q;

endmodule

// File: tb/tb_truth_table_sweep.sv
// Bench for truth_table_sweep: three instances (DWELL 4, 1, 2) each driving a
// selectable 4-input circuit; expectations come from the sweep timing rules.
module tb_truth_table_sweep;

  localparam int NU = 3;
  localparam int DW [NU] = '{4, 1, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_v   [NU];
  int          fsel      [NU];
  logic [15:0] rtt       [NU];
  logic        dut_out_v [NU];
  logic        a_v [NU], b_v [NU], c_v [NU], d_v [NU];
  logic        busy_v [NU], done_v [NU];
  logic [3:0]  idx_v  [NU];
  logic [15:0] tbl_v  [NU];
  logic [4:0]  ones_v [NU];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          unit;
    int          func;
    logic [15:0] tbl;
    int          ones;
    int          repulse;
    int          rst_at;
    bit          keep;
  } vec_t;

  vec_t vecs [8];

  // Circuit under sweep: 0 AND4, 1 XOR4, 2 constant 1, 3 ~a, else random table.
  function automatic logic circuit(input int f, input logic [15:0] r, input logic [3:0] v);
    case (f)
      0:       return &v;
      1:       return ^v;
      2:       return 1'b1;
      3:       return ~v[3];
      default: return r[v];
    endcase
  endfunction

  function automatic int popcount(input logic [15:0] t);
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(t[i]);
    return n;
  endfunction

  for (genvar g = 0; g < NU; g++) begin : g_dut
    assign dut_out_v[g] = circuit(fsel[g], rtt[g], {a_v[g], b_v[g], c_v[g], d_v[g]});
    truth_table_sweep #(.DWELL(DW[g])) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start_v[g]),
      .dut_out   (dut_out_v[g]),
      .a         (a_v[g]),
      .b         (b_v[g]),
      .c         (c_v[g]),
      .d         (d_v[g]),
      .idx       (idx_v[g]),
      .busy      (busy_v[g]),
      .done      (done_v[g]),
      .table_out (tbl_v[g]),
      .ones_cnt  (ones_v[g])
    );
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_idle_zero(input int u, input string tag);
    chk($sformatf("%s u%0d busy", tag, u), 32'(busy_v[u]), 32'd0);
    chk($sformatf("%s u%0d done", tag, u), 32'(done_v[u]), 32'd0);
    chk($sformatf("%s u%0d idx", tag, u), 32'(idx_v[u]), 32'd0);
    chk($sformatf("%s u%0d abcd", tag, u),
        32'({a_v[u], b_v[u], c_v[u], d_v[u]}), 32'd0);
    chk($sformatf("%s u%0d table", tag, u), 32'(tbl_v[u]), 32'd0);
    chk($sformatf("%s u%0d ones", tag, u), 32'(ones_v[u]), 32'd0);
  endtask

  // Called at a negedge. Start is accepted at the next posedge E; loop step n
  // samples the negedge after edge E+n. Sample k lands on edge E+(k+1)*DWELL.
  task automatic sweep(input int u, input int f, input logic [15:0] exp_tbl,
                       input int exp_ones, input int repulse, input int rst_at,
                       input bit keep);
    int          dw   = DW[u];
    int          span = 16 * dw;
    int          s;
    int          exp_idx;
    logic [15:0] part;
    fsel[u]    = f;
    start_v[u] = 1'b1;
    @(negedge clk);
    for (int n = 0; n <= span + 1; n++) begin
      if (n > 0) @(negedge clk);
      if (!keep) start_v[u] = 1'b0;
      s       = (n < span) ? n / dw : 16;
      part    = (s == 16) ? exp_tbl : (exp_tbl & 16'((32'd1 << s) - 1));
      exp_idx = (n < span) ? n / dw : ((n == span) ? 15 : 0);
      chk($sformatf("u%0d n%0d busy", u, n), 32'(busy_v[u]), 32'(n < span));
      chk($sformatf("u%0d n%0d done", u, n), 32'(done_v[u]), 32'(n == span));
      chk($sformatf("u%0d n%0d idx", u, n), 32'(idx_v[u]), 32'(exp_idx));
      chk($sformatf("u%0d n%0d abcd", u, n),
          32'({a_v[u], b_v[u], c_v[u], d_v[u]}), 32'(exp_idx));
      chk($sformatf("u%0d n%0d table", u, n), 32'(tbl_v[u]), 32'(part));
      chk($sformatf("u%0d n%0d ones", u, n), 32'(ones_v[u]), 32'(popcount(part)));
      if (n == span)
        chk($sformatf("u%0d final ones", u), 32'(ones_v[u]), 32'(exp_ones));
      if (repulse >= 0 && n == repulse * dw) start_v[u] = 1'b1;
      if (rst_at >= 0 && n == rst_at * dw) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_zero(u, "mid_sweep_rst");
        return;
      end
    end
  endtask

  initial begin
    int u;
    rst = 1'b1;
    for (int i = 0; i < NU; i++) begin
      start_v[i] = 1'b0;
      fsel[i]    = 0;
      rtt[i]     = 16'h0000;
    end
    start_v[0] = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NU; i++) check_idle_zero(i, "reset");
    start_v[0] = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    vecs[0] = '{0, 0, 16'h8000,  1, -1, -1, 1'b0};
    vecs[1] = '{1, 1, 16'h6996,  8, -1, -1, 1'b0};
    vecs[2] = '{2, 2, 16'hFFFF, 16, -1, -1, 1'b0};
    vecs[3] = '{0, 0, 16'h8000,  1,  5, -1, 1'b0};
    vecs[4] = '{0, 1, 16'h6996,  8, -1,  7, 1'b0};
    vecs[5] = '{0, 1, 16'h6996,  8, -1, -1, 1'b0};
    vecs[6] = '{1, 3, 16'h00FF,  8, -1, -1, 1'b1};
    vecs[7] = '{1, 3, 16'h00FF,  8, -1, -1, 1'b0};

    for (int i = 0; i < 8; i++) begin
      sweep(vecs[i].unit, vecs[i].func, vecs[i].tbl, vecs[i].ones,
            vecs[i].repulse, vecs[i].rst_at, vecs[i].keep);
      if (!vecs[i].keep && vecs[i].rst_at < 0) begin
        @(negedge clk);
        chk($sformatf("vec%0d idle hold table", i), 32'(tbl_v[vecs[i].unit]), 32'(vecs[i].tbl));
        chk($sformatf("vec%0d idle hold ones", i), 32'(ones_v[vecs[i].unit]), 32'(vecs[i].ones));
      end
    end

    for (int i = 0; i < 6; i++) begin
      u      = int'($urandom_range(0, NU - 1));
      rtt[u] = 16'($urandom);
      sweep(u, 4, rtt[u], popcount(rtt[u]), -1, -1, 1'b0);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/truth_table_sweep.md
TRUTH_TABLE_SWEEP -- requirements
Module: truth_table_sweep

Interface
REQ-001 The block SHALL have one parameter: DWELL, default 100, meaning clock cycles each input vector is held before the response is sampled (legal range 1..65535).
REQ-002 clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin a sweep; sampled on rising edge of clk.
REQ-005 dut_out  input  1  response of the 4-input combinational circuit under sweep.
REQ-006 a, b, c, d  output  1 each  drive the circuit inputs; {a,b,c,d} equals the current vector index, with a as MSB.
REQ-007 idx  output  4  current vector index.
REQ-008 busy  output  1  high while a sweep is in progress.
REQ-009 done  output  1  single-cycle pulse at sweep completion.
REQ-010 table_out  output  16  captured truth table; bit i holds dut_out sampled for vector i.
REQ-011 ones_cnt  output  5  number of set bits in table_out (0..16).

Function
REQ-012 The FSM SHALL have three states: IDLE, APPLY, DONE.
REQ-013 IDLE: busy=0, done=0, {a,b,c,d}=0000, idx=0; table_out and ones_cnt hold their last values.
REQ-014 IDLE with start=1 at an edge: go to APPLY; idx=0, dwell count=0, table_out=0, ones_cnt=0.
REQ-015 APPLY: busy=1; the dwell count increments every cycle while idx is held.
REQ-016 APPLY, dwell count == DWELL-1 at an edge: write dut_out into table_out[idx]; add dut_out to ones_cnt; clear dwell count.
REQ-017 At that sampling edge, if idx<15 then idx increments by 1; if idx==15 then go to DONE and idx stays at 15.
REQ-018 DONE: done=1 and busy=0 for exactly one cycle, then unconditionally go to IDLE.
REQ-019 Latency: if start is accepted at edge E, sample k (k=0..15) occurs at edge E+(k+1)*DWELL, and done is high in the cycle after edge E+16*DWELL.
REQ-020 DWELL=1 SHALL sample on every cycle, one vector per cycle, with no idle gap between vectors.
REQ-021 start while in APPLY or DONE SHALL be ignored; it does not restart or extend the sweep.
REQ-022 start held high continuously SHALL begin a new sweep in the IDLE cycle after each DONE.
REQ-023 The dwell counter width SHALL be max(1, clog2(DWELL)); it SHALL never exceed DWELL-1 (no wrap-around).
REQ-024 ones_cnt SHALL be 5 bits wide so that the value 16 is representable without overflow.

Reset
REQ-025 rst=1 at an edge, in any state including mid-sweep: state=IDLE; idx, dwell count, table_out, ones_cnt, busy and done all 0; {a,b,c,d}=0000.
REQ-026 rst SHALL take priority over start in the same cycle.
REQ-027 No partial table from an interrupted sweep SHALL survive reset.

Structure
REQ-028 A shared constants header SHALL hold the state encodings (IDLE=2'd0, APPLY=2'd1, DONE=2'd2) and NUM_VECTORS=16.
REQ-029 The dwell counter SHALL be one sub-module, dwell_timer, with inputs clk, rst, clear and enable, parameter DWELL, and output expire (count==DWELL-1).
REQ-030 The FSM, index register and capture register SHALL live in truth_table_sweep.

Verification
REQ-031 DWELL=4, DUT = a&b&c&d, pulse start -> table_out=16'h8000, ones_cnt=1, done pulses once 65 cycles after start edge.
REQ-032 DWELL=1, DUT = a^b^c^d -> table_out=16'h6996, ones_cnt=8, done 17 cycles after start; {a,b,c,d} steps 0000..1111 one per cycle.
REQ-033 DWELL=2, DUT = constant 1 -> table_out=16'hFFFF, ones_cnt=16 (5'b10000).
REQ-034 DWELL=4, start re-pulsed at idx=5 -> ignored; sweep completes at the original time with a single done pulse.
REQ-035 DWELL=4, rst asserted at idx=7 -> next cycle: busy=0, table_out=0, ones_cnt=0, abcd=0000; a fresh start then yields the full correct table.
REQ-036 start held high across two sweeps with DUT = ~a -> table_out=16'h00FF, ones_cnt=8 both times, with exactly one IDLE cycle between the two sweeps.
